ifid_pipe_reg: RTL and testbench
================================

Name: ifid_pipe_reg

Overview:
- Parametrised IF/ID pipeline register with an integrated skid buffer.
- Sits between the fetch stage (synchronous instruction memory) and decode.
- When decode stalls, the instruction already in flight from fetch is captured in the skid buffer instead of being lost. It is replayed in order when the stall releases.
- Adds valid tracking, a flush (bubble insert) and an upstream ready signal, which the previous single-register stage lacked.

Parameters:
- INST_W, 16, instruction width in bits
- PC_W, 16, width of PC+1 value
- SKID_DEPTH, 2, skid buffer entries; legal range 1..8
- NOP_INST, 0, instruction value driven when out_valid=0

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  fetch presents an instruction this cycle
- in_inst  in  INST_W  fetched instruction
- in_pc_plus1  in  PC_W  PC+1 of the fetched instruction
- in_exec  in  1  exec flag travelling with the instruction
- in_ready  out  1  stage can accept an instruction this cycle
- stall  in  1  hazard-unit stall; holds the output register
- flush  in  1  discard all held and incoming instructions (branch redirect)
- out_valid  out  1  out_inst is a real instruction
- out_inst  out  INST_W  instruction to decode
- out_pc_plus1  out  PC_W  PC+1 to decode
- out_exec  out  1  exec flag to decode
- out_stalled  out  1  stall registered by one cycle
- skid_count  out  $clog2(SKID_DEPTH+1)  current skid occupancy

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - out_valid=0, out_inst=NOP_INST, out_pc_plus1=0, out_exec=0, out_stalled=0.
  - Skid empty; skid_count=0.
  - Deasserting rst mid-stall leaves the stage empty; no buffered entry survives.
- Accept: a beat is accepted when in_valid && in_ready.
  - in_ready = (skid_count < SKID_DEPTH), computed combinationally from the registered count only. It is not a function of stall, so a push never coincides with a full buffer.
- Per rising edge, in priority order:
  1. flush=1:
     - out_valid<=0, out_inst<=NOP_INST, out_exec<=0; out_pc_plus1 holds.
     - Skid cleared.
     - Any accepted beat is discarded.
     - flush overrides stall.
  2. stall=1:
     - Output registers hold.
     - An accepted beat is pushed into the skid tail.
  3. stall=0, skid non-empty:
     - Output loads the skid head; head is popped.
     - An accepted beat is pushed in the same cycle, so the count is unchanged.
  4. stall=0, skid empty, beat accepted: output loads in_* directly (bypass, 1-cycle latency).
  5. stall=0, skid empty, no beat: out_valid<=0, out_inst<=NOP_INST, out_exec<=0; out_pc_plus1 holds.
- Ordering: strict program order. Skid entries always drain before a bypassed beat.
- Pointers: head and tail wrap modulo SKID_DEPTH, including non-power-of-two depths.
- out_stalled <= stall every non-reset cycle, including during flush.
- in_valid=0 beats are never stored; in_* are ignored when not accepted.

Optional Feature:
- Macro IFID_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles [15:0]: saturating count of cycles with stall=1 && flush=0.
  - Adds output flush_drops [15:0]: saturating count of valid instructions discarded by flush. This counts the output entry if valid, plus skid entries, plus any accepted beat.
  - Both counters reset to 0; saturate at 16'hFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package cpu_pipe_pkg holds:
  - default instruction and PC widths
  - the NOP_INST constant
  - an ifid_payload_t struct {inst, pc_plus1, exec}, shared with the ID/EX register
- One sub-module, ifid_skid_fifo, implements the circular buffer:
  - push, pop, clear
  - head data, count, full
  - parametrised by payload width and SKID_DEPTH
- The top level owns the output register, priority logic and optional counters.

Test Plan:
- Straight-line flow: stall=0, feed 0x1111/0x2222/0x3333 with pc 1/2/3 on consecutive cycles -> each appears on out_inst exactly one cycle later with out_valid=1; skid_count stays 0.
- Single-cycle stall with in-flight fetch: stall=1 for one cycle while 0x2222 arrives -> out holds 0x1111; skid_count=1; next cycle out=0x2222 and skid_count=0, order preserved.
- Fill to depth: SKID_DEPTH=2, stall held 4 cycles, in_valid=1 throughout -> in_ready drops after 2 pushes; release yields the two buffered instructions then the next fetch, no loss or duplication.
- Flush during stall: skid holds 2 entries, flush=1 with stall=1 -> next cycle out_valid=0, out_inst=0, skid_count=0, in_ready=1; with IFID_PERF_CNT_EN, flush_drops increments by 3.
- Async reset mid-operation: assert rst between edges with a full skid -> all outputs reach reset values without a clock edge; after release the first fed instruction bypasses with 1-cycle latency.
- Wrap-around: SKID_DEPTH=3, 10 alternating stall/release cycles with continuous fetch -> output sequence equals input sequence; pointers wrap correctly.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline types and constants for the fetch/decode/execute registers.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
//
// Holds the default instruction/PC widths, the bubble instruction value and
// the payload struct that travels through IF/ID and ID/EX.
package cpu_pipe_pkg;

    localparam int IFID_INST_W = 16;
    localparam int IFID_PC_W   = 16;

    // Instruction value presented to decode whenever the stage holds a bubble.
    localparam logic [IFID_INST_W-1:0] IFID_NOP_INST = '0;

    // Payload carried between pipeline registers at the default widths.
    typedef struct packed {
        logic [IFID_INST_W-1:0] inst;
        logic [IFID_PC_W-1:0]   pc_plus1;
        logic                   exec;
    } ifid_payload_t;

    localparam int IFID_PAYLOAD_W = $bits(ifid_payload_t);

endpackage

// File: rtl/ifid_skid_fifo.sv
// Circular skid buffer catching in-flight fetch beats while decode is stalled.
// Latency: a pushed entry is visible on head_dat the cycle after the push.
// Backpressure: reports full; caller must not push when full nor pop when empty.
//
// Ports: clk/rst (async active-high), push/push_dat, pop, clear (drops all
// entries, wins over push/pop), head_dat (oldest entry), count, full.
module ifid_skid_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    input  logic                       clear,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Data storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[tail] <= push_dat;
    end

    assign head_dat = mem[head];
    assign full     = (count == CNT_FULL);

endmodule

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register with skid buffer, valid tracking and flush.
// Latency: 1 cycle fetch-to-decode when the skid is empty; otherwise in order behind skid entries.
// Backpressure: in_ready drops only when the skid is full; stall never blocks acceptance directly.
//
// Ports: clk, rst (async active-high); in_valid/in_inst/in_pc_plus1/in_exec
// from fetch with in_ready back; stall and flush from the hazard unit;
// out_valid/out_inst/out_pc_plus1/out_exec/out_stalled to decode; skid_count
// exposes buffer occupancy.
// Optional macro IFID_PERF_CNT_EN adds saturating stall_cycles and
// flush_drops counters.
module ifid_pipe_reg
    import cpu_pipe_pkg::*;
#(
    parameter int                 INST_W     = IFID_INST_W,
    parameter int                 PC_W       = IFID_PC_W,
    parameter int                 SKID_DEPTH = 2,
    parameter logic [INST_W-1:0]  NOP_INST   = INST_W'(IFID_NOP_INST)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [INST_W-1:0]               in_inst,
    input  logic [PC_W-1:0]                 in_pc_plus1,
    input  logic                            in_exec,
    output logic                            in_ready,
    input  logic                            stall,
    input  logic                            flush,
    output logic                            out_valid,
    output logic [INST_W-1:0]               out_inst,
    output logic [PC_W-1:0]                 out_pc_plus1,
    output logic                            out_exec,
    output logic                            out_stalled,
    output logic [$clog2(SKID_DEPTH+1)-1:0] skid_count
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [15:0]                     stall_cycles,
    output logic [15:0]                     flush_drops
`endif
);

    localparam int PAY_W = INST_W + PC_W + 1;

    if (SKID_DEPTH < 1 || SKID_DEPTH > 8) begin : g_bad_depth
        $error("ifid_pipe_reg: SKID_DEPTH must be within 1..8");
    end

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] head_pay;
    logic             skid_full;
    logic             skid_empty;
    logic             accept;
    logic             skid_push;
    logic             skid_pop;

    assign in_pay     = {in_inst, in_pc_plus1, in_exec};
    assign in_ready   = !skid_full;
    assign skid_empty = (skid_count == '0);
    assign accept     = in_valid && in_ready;

    // A beat goes to the skid whenever it cannot go straight to the output:
    // either decode is stalled or older entries must drain first.
    assign skid_push = !flush && accept && (stall || !skid_empty);
    assign skid_pop  = !flush && !stall && !skid_empty;

    ifid_skid_fifo #(
        .W     (PAY_W),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (skid_push),
        .push_dat (in_pay),
        .pop      (skid_pop),
        .clear    (flush),
        .head_dat (head_pay),
        .count    (skid_count),
        .full     (skid_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_inst     <= NOP_INST;
            out_pc_plus1 <= '0;
            out_exec     <= 1'b0;
            out_stalled  <= 1'b0;
        end else begin
            out_stalled <= stall;
            if (flush) begin
                // Bubble; pc_plus1 is left as-is since decode ignores it.
                out_valid <= 1'b0;
                out_inst  <= NOP_INST;
                out_exec  <= 1'b0;
            end else if (stall) begin
                out_valid <= out_valid;
            end else if (!skid_empty) begin
                out_valid                            <= 1'b1;
                {out_inst, out_pc_plus1, out_exec}   <= head_pay;
            end else if (accept) begin
                out_valid    <= 1'b1;
                out_inst     <= in_inst;
                out_pc_plus1 <= in_pc_plus1;
                out_exec     <= in_exec;
            end else begin
                out_valid <= 1'b0;
                out_inst  <= NOP_INST;
                out_exec  <= 1'b0;
            end
        end
    end

`ifdef IFID_PERF_CNT_EN
    // Instructions lost to a flush: the held output, every skid entry and
    // the beat accepted in the same cycle.
    logic [3:0]  drop_n;
    logic [16:0] drop_sum;

    assign drop_n   = 4'(out_valid) + 4'(skid_count) + 4'(accept);
    assign drop_sum = {1'b0, flush_drops} + 17'(drop_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_drops  <= '0;
        end else begin
            if (stall && !flush && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (flush)
                flush_drops <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Self-checking bench for ifid_pipe_reg at skid depths 2 and 3, driven in lockstep.
// Latency: compares every cycle on the falling edge against a queue-style reference.
// Backpressure: reference decides acceptance from its own occupancy.
module tb_ifid_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_inst;
    logic [15:0] in_pc_plus1;
    logic        in_exec;
    logic        stall;
    logic        flush;

    logic        d2_in_ready, d2_out_valid, d2_out_exec, d2_out_stalled;
    logic [15:0] d2_out_inst, d2_out_pc;
    logic [1:0]  d2_skid_count;
    logic        d3_in_ready, d3_out_valid, d3_out_exec, d3_out_stalled;
    logic [15:0] d3_out_inst, d3_out_pc;
    logic [1:0]  d3_skid_count;
`ifdef IFID_PERF_CNT_EN
    logic [15:0] d2_stall_cycles, d2_flush_drops, d3_stall_cycles, d3_flush_drops;
`endif

    always #5 clk = ~clk;

    ifid_pipe_reg #(.SKID_DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst),
        .in_pc_plus1(in_pc_plus1), .in_exec(in_exec), .in_ready(d2_in_ready),
        .stall(stall), .flush(flush), .out_valid(d2_out_valid),
        .out_inst(d2_out_inst), .out_pc_plus1(d2_out_pc), .out_exec(d2_out_exec),
        .out_stalled(d2_out_stalled), .skid_count(d2_skid_count)
`ifdef IFID_PERF_CNT_EN
        , .stall_cycles(d2_stall_cycles), .flush_drops(d2_flush_drops)
`endif
    );

    ifid_pipe_reg #(.SKID_DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst),
        .in_pc_plus1(in_pc_plus1), .in_exec(in_exec), .in_ready(d3_in_ready),
        .stall(stall), .flush(flush), .out_valid(d3_out_valid),
        .out_inst(d3_out_inst), .out_pc_plus1(d3_out_pc), .out_exec(d3_out_exec),
        .out_stalled(d3_out_stalled), .skid_count(d3_skid_count)
`ifdef IFID_PERF_CNT_EN
        , .stall_cycles(d3_stall_cycles), .flush_drops(d3_flush_drops)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: output register plus an ordered list of waiting beats,
    // oldest at index 0. Payload is {inst, pc_plus1, exec}.
    int          dep [2] = '{2, 3};
    logic        m_valid   [2];
    logic [15:0] m_inst    [2];
    logic [15:0] m_pc      [2];
    logic        m_exec    [2];
    logic        m_stalled [2];
    logic [32:0] m_skid    [2][8];
    int          m_cnt     [2];
    int          m_stall_cyc [2];
    int          m_drops     [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_inst[k] = 16'h0; m_pc[k] = 16'h0;
            m_exec[k] = 1'b0; m_stalled[k] = 1'b0; m_cnt[k] = 0;
            m_stall_cyc[k] = 0; m_drops[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic v, input logic [15:0] inst,
                              input logic [15:0] pc, input logic ex,
                              input logic st, input logic fl);
        logic        acc;
        logic [32:0] beat;
        beat = {inst, pc, ex};
        acc  = v && (m_cnt[k] < dep[k]);
        m_stalled[k] = st;
        if (st && !fl && m_stall_cyc[k] < 65535) m_stall_cyc[k]++;
        if (fl) begin
            m_drops[k] = m_drops[k] + int'(m_valid[k]) + m_cnt[k] + int'(acc);
            if (m_drops[k] > 65535) m_drops[k] = 65535;
            m_valid[k] = 1'b0; m_inst[k] = 16'h0; m_exec[k] = 1'b0; m_cnt[k] = 0;
        end else if (st) begin
            if (acc) begin m_skid[k][m_cnt[k]] = beat; m_cnt[k]++; end
        end else if (m_cnt[k] > 0) begin
            {m_inst[k], m_pc[k], m_exec[k]} = m_skid[k][0];
            m_valid[k] = 1'b1;
            for (int i = 0; i < 7; i++) m_skid[k][i] = m_skid[k][i+1];
            m_cnt[k]--;
            if (acc) begin m_skid[k][m_cnt[k]] = beat; m_cnt[k]++; end
        end else if (acc) begin
            m_valid[k] = 1'b1; m_inst[k] = inst; m_pc[k] = pc; m_exec[k] = ex;
        end else begin
            m_valid[k] = 1'b0; m_inst[k] = 16'h0; m_exec[k] = 1'b0;
        end
    endtask

    task automatic check_dut(input int k, input string p, input logic ov,
                             input logic [15:0] oi, input logic [15:0] op,
                             input logic oe, input logic os,
                             input logic [1:0] sc, input logic ir);
        chk({p, ".out_valid"},   32'(ov), 32'(m_valid[k]));
        chk({p, ".out_inst"},    32'(oi), 32'(m_inst[k]));
        chk({p, ".out_pc"},      32'(op), 32'(m_pc[k]));
        chk({p, ".out_exec"},    32'(oe), 32'(m_exec[k]));
        chk({p, ".out_stalled"}, 32'(os), 32'(m_stalled[k]));
        chk({p, ".skid_count"},  32'(sc), 32'(m_cnt[k]));
        chk({p, ".in_ready"},    32'(ir), 32'(m_cnt[k] < dep[k]));
    endtask

    task automatic check_all();
        check_dut(0, "d2", d2_out_valid, d2_out_inst, d2_out_pc, d2_out_exec,
                  d2_out_stalled, d2_skid_count, d2_in_ready);
        check_dut(1, "d3", d3_out_valid, d3_out_inst, d3_out_pc, d3_out_exec,
                  d3_out_stalled, d3_skid_count, d3_in_ready);
`ifdef IFID_PERF_CNT_EN
        chk("d2.stall_cycles", 32'(d2_stall_cycles), 32'(m_stall_cyc[0]));
        chk("d2.flush_drops",  32'(d2_flush_drops),  32'(m_drops[0]));
        chk("d3.stall_cycles", 32'(d3_stall_cycles), 32'(m_stall_cyc[1]));
        chk("d3.flush_drops",  32'(d3_flush_drops),  32'(m_drops[1]));
`endif
    endtask

    // Called just after a falling edge: drive, advance the reference, then
    // compare after the rising edge has been absorbed.
    task automatic cycle(input logic v, input logic [15:0] inst, input logic [15:0] pc,
                         input logic ex, input logic st, input logic fl);
        in_valid = v; in_inst = inst; in_pc_plus1 = pc; in_exec = ex;
        stall = st; flush = fl;
        model_step(0, v, inst, pc, ex, st, fl);
        model_step(1, v, inst, pc, ex, st, fl);
        @(negedge clk);
        check_all();
    endtask

    // Reset asserted between edges: outputs must clear with no clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_inst = 16'h0; in_pc_plus1 = 16'h0; in_exec = 1'b0;
        stall = 1'b0; flush = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Straight-line flow
        cycle(1, 16'h1111, 16'd1, 1'b0, 1'b0, 1'b0);
        cycle(1, 16'h2222, 16'd2, 1'b1, 1'b0, 1'b0);
        cycle(1, 16'h3333, 16'd3, 1'b0, 1'b0, 1'b0);
        cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Single-cycle stall with an in-flight fetch
        cycle(1, 16'h1111, 16'd1, 1'b0, 1'b0, 1'b0);
        cycle(1, 16'h2222, 16'd2, 1'b0, 1'b1, 1'b0);
        cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Fill to depth, then release with fetch continuing
        for (int i = 0; i < 4; i++) cycle(1, 16'hA000 + 16'(i), 16'(i), 1'b1, 1'b1, 1'b0);
        for (int i = 4; i < 9; i++) cycle(1, 16'hA000 + 16'(i), 16'(i), 1'b0, 1'b0, 1'b0);
        cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Flush during stall with two buffered entries
        cycle(1, 16'hB001, 16'd1, 1'b0, 1'b0, 1'b0);
        cycle(1, 16'hB002, 16'd2, 1'b0, 1'b1, 1'b0);
        cycle(1, 16'hB003, 16'd3, 1'b0, 1'b1, 1'b0);
        cycle(1, 16'hB004, 16'd4, 1'b0, 1'b1, 1'b1);
        cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Async reset with a full skid, then a bypassed beat
        for (int i = 0; i < 4; i++) cycle(1, 16'hC000 + 16'(i), 16'(i), 1'b0, 1'b1, 1'b0);
        async_reset();
        cycle(1, 16'hBEEF, 16'h0042, 1'b1, 1'b0, 1'b0);
        cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Alternating stall/release with continuous fetch (pointer wrap)
        for (int i = 0; i < 10; i++)
            cycle(1, 16'hD000 + 16'(i), 16'(i), 1'(i % 2), 1'((i % 2) == 0), 1'b0);
        for (int i = 0; i < 4; i++) cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) async_reset();
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4),
                  1'($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
